// File: rtl/accu_sched_pkg.sv
// Shared constants and helpers for the round-robin accumulator scheduler.
package accu_sched_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int DATA_W_DEF  = 8;
  localparam int BURST_DEF   = 4;
  localparam int SUM_W_DEF   = 10;
  localparam int TIMEOUT_DEF = 15;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_FEED = 2'd1;
  localparam state_t ST_WAIT = 2'd2;
  localparam state_t ST_RESP = 2'd3;

  function automatic int calc_id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/accu_sched_rr_arbiter.sv
// Combinational round-robin pick: first request after ptr_i, wrapping modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  idx_o
);

  int              cand;
  logic [ID_W-1:0] cidx;
  logic            found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    cidx  = '0;
    if (en_i) begin
      for (int k = 1; k <= N_REQ; k++) begin
        cand = (int'(ptr_i) + k) % N_REQ;
        cidx = ID_W'(cand);
        if (!found && req_i[cidx]) begin
          found       = 1'b1;
          gnt_o[cidx] = 1'b1;
          idx_o       = cidx;
        end
      end
    end
  end

endmodule

// File: rtl/accu_sched.sv
// Shares one BURST-beat accumulator between N_REQ requesters, round-robin,
// and returns each sum tagged with the requester id over a valid/ready port.
module accu_sched
  import accu_sched_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int BURST   = BURST_DEF,
  parameter int SUM_W   = SUM_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int ID_W    = calc_id_w(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    acc_valid_in,
  output logic [DATA_W-1:0]       acc_data_in,
  input  logic                    acc_valid_out,
  input  logic [SUM_W-1:0]        acc_data_out,
  output logic                    res_valid,
  output logic [ID_W-1:0]         res_id,
  output logic [SUM_W-1:0]        res_data,
  input  logic                    res_ready,
  output logic                    busy,
  output logic                    err_pulse
);

  localparam int BW = $clog2(BURST + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              acc_valid_q;
  logic [DATA_W-1:0] acc_data_q;
  logic              res_valid_q;
  logic [ID_W-1:0]   res_id_q;
  logic [SUM_W-1:0]  res_data_q;
  logic              err_q;

  logic [N_REQ-1:0]  gnt_oh;
  logic [ID_W-1:0]   arb_idx;
  logic [DATA_W-1:0] gnt_sample;
  logic              beat, gap, last_beat, res_hit, tmo_hit, xfer;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .en_i  (state_q == ST_IDLE),
    .gnt_o (gnt_oh),
    .idx_o (arb_idx)
  );

  always_comb begin
    gnt_sample = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q == ID_W'(i)) gnt_sample = req_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == ST_FEED) req_ready[grant_q] = 1'b1;
  end

  assign beat      = (state_q == ST_FEED) && req_valid[grant_q];
  assign gap       = (state_q == ST_FEED) && !req_valid[grant_q];
  assign last_beat = beat && (beat_q == BW'(BURST - 1));
  // A result arriving on the final timeout cycle takes precedence over the abort.
  assign res_hit   = (state_q == ST_WAIT) && acc_valid_out;
  assign tmo_hit   = (state_q == ST_WAIT) && !acc_valid_out && (tmo_q == TW'(TIMEOUT - 1));
  assign xfer      = (state_q == ST_RESP) && res_ready;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (|gnt_oh) begin
          grant_d = arb_idx;
          beat_d  = '0;
          tmo_d   = '0;
          state_d = ST_FEED;
        end
      end
      ST_FEED: begin
        if (gap) begin
          ptr_d   = grant_q;
          state_d = ST_IDLE;
        end else if (last_beat) begin
          state_d = ST_WAIT;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (res_hit) begin
          state_d = ST_RESP;
        end else if (tmo_hit) begin
          ptr_d   = grant_q;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (xfer) begin
          ptr_d   = grant_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      ptr_q       <= ID_W'(N_REQ - 1);
      beat_q      <= '0;
      tmo_q       <= '0;
      acc_valid_q <= 1'b0;
      acc_data_q  <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      beat_q      <= beat_d;
      tmo_q       <= tmo_d;
      acc_valid_q <= beat;
      err_q       <= gap || tmo_hit;
      if (beat) acc_data_q <= gnt_sample;
      if (res_hit) begin
        res_valid_q <= 1'b1;
        res_id_q    <= grant_q;
        res_data_q  <= acc_data_out;
      end else if (xfer) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign acc_valid_in = acc_valid_q;
  assign acc_data_in  = acc_data_q;
  assign res_valid    = res_valid_q;
  assign res_id       = res_id_q;
  assign res_data     = res_data_q;
  assign err_pulse    = err_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_accu_sched.sv
// Directed bench for accu_sched with a behavioural 4-beat accumulator model.
module tb_accu_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        acc_valid_in;
  logic [7:0]  acc_data_in;
  logic        acc_valid_out;
  logic [9:0]  acc_data_out;
  logic        res_valid;
  logic [1:0]  res_id;
  logic [9:0]  res_data;
  logic        res_ready;
  logic        busy;
  logic        err_pulse;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  accu_sched #(
    .N_REQ   (4),
    .DATA_W  (8),
    .BURST   (4),
    .SUM_W   (10),
    .TIMEOUT (15)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .acc_valid_in  (acc_valid_in),
    .acc_data_in   (acc_data_in),
    .acc_valid_out (acc_valid_out),
    .acc_data_out  (acc_data_out),
    .res_valid     (res_valid),
    .res_id        (res_id),
    .res_data      (res_data),
    .res_ready     (res_ready),
    .busy          (busy),
    .err_pulse     (err_pulse)
  );

  // Requester sources: sample stores with a consumed index and an available limit.
  int         pos[4] = '{default: 0};
  int         lim[4] = '{default: 0};
  logic [7:0] samp[4][64];

  always_comb begin
    req_valid = '0;
    req_data  = '0;
    for (int i = 0; i < 4; i++) begin
      req_valid[i]       = (pos[i] < lim[i]);
      req_data[i*8 +: 8] = samp[i][pos[i][5:0]];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i] && req_ready[i]) pos[i] <= pos[i] + 1;
    end
  end

  // Accumulator model: sums 4 contiguous strobes, restarts on any idle cycle.
  logic       model_en;
  int         m_cnt;
  logic [9:0] m_sum;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt         <= 0;
      m_sum         <= '0;
      acc_valid_out <= 1'b0;
      acc_data_out  <= '0;
    end else begin
      acc_valid_out <= 1'b0;
      if (model_en && acc_valid_in) begin
        if (m_cnt == 3) begin
          acc_valid_out <= 1'b1;
          acc_data_out  <= m_sum + 10'(acc_data_in);
          m_cnt         <= 0;
          m_sum         <= '0;
        end else begin
          m_cnt <= m_cnt + 1;
          m_sum <= m_sum + 10'(acc_data_in);
        end
      end else begin
        m_cnt <= 0;
        m_sum <= '0;
      end
    end
  end

  int run = 0, last_run = 0, err_hi = 0, res_hi = 0;

  always @(negedge clk) begin
    if (acc_valid_in) run <= run + 1;
    else if (run != 0) begin
      last_run <= run;
      run      <= 0;
    end
    if (err_pulse) err_hi <= err_hi + 1;
    if (res_valid) res_hi <= res_hi + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic push(input int i, input int v);
    samp[i][6'(lim[i])] = 8'(v);
    lim[i] = lim[i] + 1;
  endtask

  task automatic push4(input int i, input int a, input int b, input int c, input int d);
    push(i, a); push(i, b); push(i, c); push(i, d);
  endtask

  task automatic exp_resp(input string tag, input int id, input int sum);
    int n;
    n = 0;
    while (res_valid !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".vld"}, int'(res_valid), 1);
    chk({tag, ".id"}, int'(res_id), id);
    chk({tag, ".sum"}, int'(res_data), sum);
    @(negedge clk);
  endtask

  int e0, r0, n;

  initial begin
    rst       = 1'b1;
    res_ready = 1'b1;
    model_en  = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.busy", int'(busy), 0);
    chk("rst.ready", int'(req_ready), 0);
    chk("rst.accv", int'(acc_valid_in), 0);
    chk("rst.resv", int'(res_valid), 0);
    chk("rst.err", int'(err_pulse), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single burst from requester 0
    push4(0, 10, 20, 30, 40);
    exp_resp("t1", 0, 100);
    chk("t1.busy", int'(busy), 0);
    chk("t1.resv_low", int'(res_valid), 0);
    chk("t1.strobes", last_run, 4);

    // Full-scale samples, no overflow
    push4(1, 255, 255, 255, 255);
    exp_resp("t3", 1, 1020);

    // Gap after two beats from requester 3
    e0 = err_hi;
    r0 = res_hi;
    push(3, 5); push(3, 6);
    repeat (12) @(negedge clk);
    chk("gap.err_cycles", err_hi - e0, 1);
    chk("gap.no_resp", res_hi - r0, 0);
    chk("gap.busy", int'(busy), 0);
    push4(0, 1, 2, 3, 4);
    push4(3, 7, 8, 9, 10);
    exp_resp("gap.next0", 0, 10);
    exp_resp("gap.next3", 3, 34);

    // Two continuously valid requesters alternate
    push4(0, 11, 12, 13, 14); push4(0, 15, 16, 17, 18);
    push4(2, 100, 101, 102, 103); push4(2, 200, 201, 202, 203);
    exp_resp("rr.a", 0, 50);
    exp_resp("rr.b", 2, 406);
    exp_resp("rr.c", 0, 66);
    exp_resp("rr.d", 2, 806);

    // Accumulator never answers
    model_en = 1'b0;
    e0 = err_hi;
    r0 = res_hi;
    push4(1, 1, 1, 1, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (err_pulse !== 1'b1 && n < 40);
    chk("tmo.cycles", n, 20);
    chk("tmo.busy", int'(busy), 0);
    @(negedge clk);
    chk("tmo.err_width", int'(err_pulse), 0);
    chk("tmo.err_cycles", err_hi - e0, 1);
    chk("tmo.no_resp", res_hi - r0, 0);
    model_en = 1'b1;

    // Response back-pressure
    res_ready = 1'b0;
    r0 = res_hi;
    push4(2, 50, 60, 70, 80);
    n = 0;
    while (res_valid !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("bp.vld", int'(res_valid), 1);
    chk("bp.id", int'(res_id), 2);
    chk("bp.sum", int'(res_data), 260);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp.hold_vld", int'(res_valid), 1);
      chk("bp.hold_id", int'(res_id), 2);
      chk("bp.hold_sum", int'(res_data), 260);
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp.drop", int'(res_valid), 0);
    @(negedge clk);
    chk("bp.vld_cycles", res_hi - r0, 6);
    chk("bp.busy", int'(busy), 0);

    // Reset in the middle of a burst
    e0 = err_hi;
    push(3, 9); push4(3, 20, 21, 22, 23);
    @(negedge clk);
    chk("mr.ready", int'(req_ready), 8);
    chk("mr.busy_pre", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mr.busy", int'(busy), 0);
    chk("mr.ready0", int'(req_ready), 0);
    chk("mr.accv", int'(acc_valid_in), 0);
    chk("mr.accd", int'(acc_data_in), 0);
    chk("mr.resv", int'(res_valid), 0);
    chk("mr.resid", int'(res_id), 0);
    chk("mr.resd", int'(res_data), 0);
    chk("mr.err", int'(err_pulse), 0);
    rst = 1'b0;
    push4(0, 1, 1, 1, 1);
    exp_resp("mr.first0", 0, 4);
    exp_resp("mr.then3", 3, 86);
    chk("mr.no_err", err_hi - e0, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/accu_sched.md
Name: accu_sched

Overview:
- Round-robin scheduler that shares one 4-beat accumulator datapath (8-bit samples in, 10-bit sum out) between N_REQ requesters.
- Grants one requester at a time and streams its burst of BURST samples into the accumulator.
- Waits for the accumulator result, then returns the result tagged with the requester id over a valid/ready response port.
- Sits between the sample producers and the shared accumulator instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 8, sample width.
- BURST, 4, samples per accumulation.
- SUM_W, 10, result width; must equal DATA_W + clog2(BURST).
- TIMEOUT, 15, max cycles in WAIT before abort.
- ID_W, derived, clog2(N_REQ) with a minimum of 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  N_REQ  per-requester sample valid.
- req_data  in  N_REQ*DATA_W  per-requester sample; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  N_REQ  per-requester sample accept.
- acc_valid_in  out  1  sample strobe to the accumulator.
- acc_data_in  out  DATA_W  sample to the accumulator.
- acc_valid_out  in  1  accumulator result strobe.
- acc_data_out  in  SUM_W  accumulator result.
- res_valid  out  1  response valid.
- res_id  out  ID_W  granted requester index.
- res_data  out  SUM_W  captured sum.
- res_ready  in  1  response accept.
- busy  out  1  high in any state other than IDLE.
- err_pulse  out  1  one-cycle pulse on abort (gap or timeout).

Behaviour:
- Reset (synchronous, takes priority over everything):
  - State = IDLE; beat counter and timeout counter = 0.
  - Round-robin pointer = N_REQ-1, so requester 0 has first priority.
  - acc_valid_in, acc_data_in, res_valid, res_id, res_data, err_pulse and busy all = 0.
  - Reset mid-operation discards the burst in progress silently: no err_pulse and no response.
- IDLE:
  - If any req_valid is high, select the first requester with req_valid set, searching from pointer+1 and wrapping modulo N_REQ.
  - Latch the selection as grant; go to FEED on the next cycle.
- FEED:
  - req_ready[grant] = 1 combinationally; all other req_ready bits = 0. req_ready is 0 in every other state.
  - Beat = req_valid[grant] && req_ready[grant].
  - On each beat, register acc_valid_in = 1 and acc_data_in = the granted sample, one-cycle latency.
  - acc_valid_in = 0 on all non-beat cycles.
  - When the beat counter reaches BURST, go to WAIT.
  - A cycle with req_valid[grant] = 0 before BURST beats is a gap. On a gap: pulse err_pulse, pointer = grant, return to IDLE.
  - Bursts must be contiguous because the accumulator restarts its count on an idle cycle.
- WAIT:
  - The timeout counter increments every cycle.
  - On acc_valid_out = 1: capture res_data = acc_data_out and res_id = grant, set res_valid = 1, go to RESP.
  - If the counter reaches TIMEOUT first: pulse err_pulse, pointer = grant, go to IDLE.
  - If acc_valid_out and the timeout coincide, the result wins.
- RESP:
  - Hold res_valid, res_id and res_data stable until res_ready = 1.
  - On transfer: res_valid = 0 on the next edge, pointer = grant, go to IDLE.
  - res_ready may already be high in the cycle res_valid first rises; the transfer happens in that cycle.
- Timing and ordering:
  - IDLE always lasts at least one cycle, so there is no grant in the same cycle as a RESP transfer.
  - Minimum latency from grant to res_valid: BURST + accumulator latency + 1 cycles.
  - acc_valid_out outside WAIT is ignored.
  - Requesters that are not granted see req_ready = 0 and must hold their data.

Decomposition:
- Package accu_sched_pkg holds:
  - the state enum {IDLE, FEED, WAIT, RESP};
  - the default parameter constants;
  - the ID_W computation function.
- Sub-module rr_arbiter (N_REQ): inputs are the request vector, the pointer and an enable; outputs are a one-hot grant and a binary index. Purely combinational priority rotation.
- FSM, counters and response register stay in accu_sched.

Test Plan (bench uses a behavioural 4-beat accumulator model):
- Req0 streams 10, 20, 30, 40 -> acc_valid_in strobes 4 consecutive cycles; res_valid with res_id=0, res_data=100; busy falls after the transfer.
- Req0 and req2 both continuously valid -> grant order 0, 2, 0, 2; responses carry sums of 4 samples each with the matching ids.
- Req1 streams 255 x4 -> res_data=1020 with no overflow; res_id=1.
- Req3 drops req_valid after 2 beats -> err_pulse for 1 cycle, no res_valid, next grant goes to a requester after 3 (wraps to 0).
- Model never asserts acc_valid_out -> err_pulse after 15 WAIT cycles, return to IDLE, busy=0.
- res_ready held low 5 cycles in RESP -> res_valid/res_id/res_data stable, then a single transfer. Then assert rst during FEED -> all outputs 0 next cycle and requester 0 is granted first afterwards.
